// File: rtl/rv_trace_buffer_if.sv
// rv_trace_buffer_if: capture/readout bundle between the rv_mc core side and the trace buffer.
// Optional feature macro: TRACE_PC_FILTER_EN adds the filt_lo/filt_hi pc window inputs.
interface rv_trace_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // capture side
  logic            clear;
  logic            cap_en;
  logic            we_pc;
  logic            we_rf;
  logic            we_mem;
  logic [XLEN-1:0] pc;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rf_wdata;
`ifdef TRACE_PC_FILTER_EN
  logic [XLEN-1:0] filt_lo;
  logic [XLEN-1:0] filt_hi;
`endif

  // readout side
  logic            rd_ready;
  logic            rd_valid;
  logic [TS_W-1:0] rd_ts;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_insn;
  logic [3:0]      rd_flags;
  logic [XLEN-1:0] rd_data;
  logic [CW-1:0]   count;
  logic [15:0]     dropped;
  logic [1:0]      state;

  modport master (
    output clear, cap_en, we_pc, we_rf, we_mem, pc, instruction, rf_wdata, rd_ready,
`ifdef TRACE_PC_FILTER_EN
    output filt_lo, filt_hi,
`endif
    input  rd_valid, rd_ts, rd_pc, rd_insn, rd_flags, rd_data, count, dropped, state
  );

  modport slave (
    input  clear, cap_en, we_pc, we_rf, we_mem, pc, instruction, rf_wdata, rd_ready,
`ifdef TRACE_PC_FILTER_EN
    input  filt_lo, filt_hi,
`endif
    output rd_valid, rd_ts, rd_pc, rd_insn, rd_flags, rd_data, count, dropped, state
  );
endinterface

// File: rtl/rv_trace_buffer.sv
// rv_trace_buffer: retirement-trace capture ring with timestamp, trigger/post-capture and freeze.
// Optional feature macro: TRACE_PC_FILTER_EN restricts capture to filt_lo <= pc <= filt_hi.
module rv_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_W      = 32,
  parameter logic [31:0] TRIG_INSN = 32'h00002083,
  parameter int unsigned POST_CNT  = 4,
  parameter int unsigned WRAP_MODE = 1
) (
  input logic              clk,
  input logic              rst,
  rv_trace_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_POST   = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [3:0]      flags;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_c;
  logic [AW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   count_q;
  logic [15:0]     dropped_q;
  logic [TS_W-1:0] ts_q;
  state_t          state_q, state_d;
  logic [PW-1:0]   post_q, post_d;

  logic trig_c, in_range_c, ev_c, full_c, rd_valid_c, pop_c, push_c, drop_c, adv_rp_c;

  // Event qualification and push/pop/drop decisions
  always_comb begin
    trig_c = (bus.instruction == TRIG_INSN);
`ifdef TRACE_PC_FILTER_EN
    in_range_c = (bus.pc >= bus.filt_lo) && (bus.pc <= bus.filt_hi);
`else
    in_range_c = 1'b1;
`endif
    ev_c       = bus.cap_en & (bus.we_pc | bus.we_rf | bus.we_mem | trig_c) & in_range_c
                 & (state_q != ST_FROZEN) & ~bus.clear;
    full_c     = (count_q == CW'(DEPTH));
    rd_valid_c = (count_q != '0);
    pop_c      = rd_valid_c & bus.rd_ready;
    // a full buffer without a pop either overwrites the oldest entry or sheds the new one
    push_c     = ev_c & (~full_c | pop_c | (WRAP_MODE != 0));
    drop_c     = ev_c & full_c & ~pop_c;
    adv_rp_c   = pop_c | (drop_c & (WRAP_MODE != 0));
  end

  // Trigger FSM next-state: advances only on events that actually land in storage
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    case (state_q)
      ST_RUN: begin
        if (push_c && trig_c) begin
          state_d = (POST_CNT == 0) ? ST_FROZEN : ST_POST;
          post_d  = PW'(POST_CNT);
        end
      end
      ST_POST: begin
        if (push_c) begin
          if (post_q <= PW'(1)) begin
            state_d = ST_FROZEN;
            post_d  = '0;
          end else begin
            post_d = post_q - PW'(1);
          end
        end
      end
      ST_FROZEN: ;
      default: state_d = ST_RUN;
    endcase
    if (bus.clear) begin
      state_d = ST_RUN;
      post_d  = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  // Pointers, occupancy, drop counter and free-running timestamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      ts_q      <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (bus.clear) begin
        wp_q      <= '0;
        rp_q      <= '0;
        count_q   <= '0;
        dropped_q <= '0;
      end else begin
        if (push_c)   wp_q <= wp_q + AW'(1);
        if (adv_rp_c) rp_q <= rp_q + AW'(1);
        if (push_c && !adv_rp_c)       count_q <= count_q + CW'(1);
        else if (!push_c && pop_c)     count_q <= count_q - CW'(1);
        if (drop_c && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wp_q] <= '{ts:    ts_q,
                     pc:    bus.pc,
                     insn:  bus.instruction,
                     flags: {trig_c, bus.we_mem, bus.we_rf, bus.we_pc},
                     data:  bus.rf_wdata};
    end
  end

  // Head entry is presented straight from storage, zeroed while empty
  always_comb begin
    head_c = rd_valid_c ? mem[rp_q] : '0;
  end

  assign bus.rd_valid = rd_valid_c;
  assign bus.rd_ts    = head_c.ts;
  assign bus.rd_pc    = head_c.pc;
  assign bus.rd_insn  = head_c.insn;
  assign bus.rd_flags = head_c.flags;
  assign bus.rd_data  = head_c.data;
  assign bus.count    = count_q;
  assign bus.dropped  = dropped_q;
  assign bus.state    = 2'(state_q);
endmodule
